// File: rtl/router_pkg.sv
// Shared types and helpers for the 1x3 router packet-sequencing controller.
package router_pkg;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    WAIT_TILL_EMPTY    = 3'd1,
    LOAD_FIRST_DATA    = 3'd2,
    LOAD_DATA          = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    LOAD_PARITY        = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } router_state_e;

  localparam logic [1:0] ADDR_INVALID    = 2'd3;
  localparam int         DEFAULT_TIMEOUT = 30;

  // Per-port flag lookup; the invalid address 3 reads as 0 instead of out of range.
  function automatic logic port_bit(input logic [2:0] v, input logic [1:0] a);
    case (a)
      2'd0:    return v[0];
      2'd1:    return v[1];
      2'd2:    return v[2];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] port_onehot(input logic [1:0] a);
    case (a)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      2'd2:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/router_sr_timer.sv
// Read-timeout watchdog for one output port: counts unread cycles and
// emits a one-cycle registered soft_reset when the limit is reached.
module router_sr_timer
  import router_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int TW      = $clog2(TIMEOUT + 1)
) (
  input  logic clock,
  input  logic rstn,
  input  logic vld,
  input  logic rd,
  output logic soft_reset
);

  logic [TW-1:0] cnt;
  logic          stall;
  logic          expire;

  assign stall  = vld && !rd;
  assign expire = stall && (cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      cnt        <= '0;
      soft_reset <= 1'b0;
    end else begin
      soft_reset <= expire;
      if (stall && !expire) begin
        cnt <= cnt + TW'(1);
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/router_ctrl.sv
// Packet-sequencing FSM for the 1x3 router: steers writes into the selected
// FIFO, drives register-block strobes and busy, and hosts per-port watchdogs.
module router_ctrl
  import router_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int TW      = $clog2(TIMEOUT + 1)
) (
  input  logic       clock,
  input  logic       rstn,
  input  logic       pkt_valid,
  input  logic [7:0] data_in,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  input  logic [2:0] fifo_full,
  input  logic [2:0] fifo_empty,
  input  logic [2:0] vld_out,
  input  logic [2:0] read_enb,
  output logic       busy,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       rst_int_reg,
  output logic [2:0] write_enb,
  output logic [2:0] soft_reset
);

  router_state_e state;
  router_state_e state_nxt;
  logic [1:0]    addr_q;
  logic [1:0]    hdr_addr;
  logic          hdr_ok;
  logic          cur_full;
  logic          cur_sr;
  logic          load_w;
  logic          unused_hdr;

  assign hdr_addr   = data_in[1:0];
  assign hdr_ok     = pkt_valid && (hdr_addr != ADDR_INVALID);
  assign cur_full   = port_bit(fifo_full, addr_q);
  assign cur_sr     = port_bit(soft_reset, addr_q);
  assign unused_hdr = ^data_in[7:2];

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state <= DECODE_ADDRESS;
    end else begin
      state <= state_nxt;
    end
  end

  // The destination is captured once, as the header leaves DECODE_ADDRESS.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      addr_q <= 2'd0;
    end else if ((state == DECODE_ADDRESS) && (state_nxt != DECODE_ADDRESS)) begin
      addr_q <= hdr_addr;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DECODE_ADDRESS: begin
        if (hdr_ok) begin
          state_nxt = port_bit(fifo_empty, hdr_addr) ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
      end
      WAIT_TILL_EMPTY: begin
        if (port_bit(fifo_empty, addr_q)) state_nxt = LOAD_FIRST_DATA;
      end
      LOAD_FIRST_DATA: state_nxt = LOAD_DATA;
      LOAD_DATA: begin
        if (cur_full)        state_nxt = FIFO_FULL_STATE;
        else if (!pkt_valid) state_nxt = LOAD_PARITY;
      end
      FIFO_FULL_STATE: begin
        if (!cur_full) state_nxt = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        if (parity_done)        state_nxt = DECODE_ADDRESS;
        else if (low_pkt_valid) state_nxt = LOAD_PARITY;
        else                    state_nxt = LOAD_DATA;
      end
      LOAD_PARITY: state_nxt = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: begin
        state_nxt = cur_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      end
      default: state_nxt = DECODE_ADDRESS;
    endcase
    // A flush of the active FIFO abandons the packet from any state.
    if ((state != DECODE_ADDRESS) && cur_sr) begin
      state_nxt = DECODE_ADDRESS;
    end
  end

  always_comb begin
    busy        = 1'b1;
    detect_add  = 1'b0;
    lfd_state   = 1'b0;
    ld_state    = 1'b0;
    laf_state   = 1'b0;
    full_state  = 1'b0;
    rst_int_reg = 1'b0;
    load_w      = 1'b0;
    case (state)
      DECODE_ADDRESS: begin
        busy       = 1'b0;
        detect_add = 1'b1;
      end
      LOAD_FIRST_DATA: begin
        lfd_state = 1'b1;
        load_w    = 1'b1;
      end
      LOAD_DATA: begin
        busy     = 1'b0;
        ld_state = 1'b1;
        load_w   = 1'b1;
      end
      FIFO_FULL_STATE:    full_state  = 1'b1;
      LOAD_AFTER_FULL: begin
        laf_state = 1'b1;
        load_w    = 1'b1;
      end
      LOAD_PARITY:        load_w      = 1'b1;
      CHECK_PARITY_ERROR: rst_int_reg = 1'b1;
      default:            busy        = 1'b1;
    endcase
    write_enb = load_w ? port_onehot(addr_q) : 3'b000;
  end

  for (genvar i = 0; i < 3; i++) begin : g_timer
    router_sr_timer #(
      .TIMEOUT (TIMEOUT),
      .TW      (TW)
    ) u_timer (
      .clock      (clock),
      .rstn       (rstn),
      .vld        (vld_out[i]),
      .rd         (read_enb[i]),
      .soft_reset (soft_reset[i])
    );
  end

endmodule
